// File: rtl/scramble_line_scheduler.sv
// scramble_line_scheduler
//   Sequences the per-line scrambler. The block watches the BT.656 stream for
//   TRS codes and fetches one DRBG word for each active line. It reduces that
//   word to a cut position in 0..ACTIVE_SAMPLES-1 and presents the cut to the
//   line rotator from SAV+1 through EAV. It also counts frames and reseeds the
//   DRBG every RESEED_FRAMES frames.
// Ports
//   clk, reset_n      : clock, synchronous active-low reset
//   enable            : 0 parks the block in IDLE at the next line end
//   bt656_in[9:0]     : monitored BT.656 word stream
//   drbg_init/_ready  : one-cycle reseed request / reseed done
//   drbg_next         : word request, held until drbg_bits_ready
//   drbg_bits_ready   : drbg_bits valid this cycle
//   drbg_bits[15:0]   : random word from the DRBG
//   cut_position      : rotation point for the current active line
//   cut_valid         : cut_position applies (SAV+1 .. EAV XY word)
//   field, vblank     : F and V bits of the last TRS
//   frame_count[15:0] : frames since reset
//   error_missed      : sticky, an active line began with no word available
module scramble_line_scheduler #(
  parameter int ACTIVE_SAMPLES = 1440,
  parameter int CUT_WIDTH      = 11,
  parameter int RESEED_FRAMES  = 60
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [9:0]           bt656_in,
  output logic                 drbg_init,
  input  logic                 drbg_init_ready,
  output logic                 drbg_next,
  input  logic                 drbg_bits_ready,
  input  logic [15:0]          drbg_bits,
  output logic [CUT_WIDTH-1:0] cut_position,
  output logic                 cut_valid,
  output logic                 field,
  output logic                 vblank,
  output logic [15:0]          frame_count,
  output logic                 error_missed
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEED, S_SEED_WAIT, S_WAIT_EAV, S_REQ, S_HOLD, S_RUN
  } state_t;

  localparam logic [CUT_WIDTH-1:0] ACT_N     = CUT_WIDTH'(ACTIVE_SAMPLES);
  localparam logic [15:0]          RESEED_N  = 16'(RESEED_FRAMES);
  localparam bit                   RESEED_EN = (RESEED_FRAMES != 0);

  state_t                 state_q, state_d;
  logic [2:0][9:0]        hist_q, hist_d;
  logic                   field_q, field_d, vblank_q, vblank_d;
  logic [15:0]            word_q, word_d;
  logic [CUT_WIDTH-1:0]   cut_position_q, cut_position_d;
  logic                   cut_valid_q, cut_valid_d;
  logic [15:0]            frame_count_q, frame_count_d;
  logic [15:0]            seed_cnt_q, seed_cnt_d;
  logic                   error_missed_q, error_missed_d;

  logic                   trs, eav, sav_act, frame_tick, reseed_now, in_line;
  logic [CUT_WIDTH-1:0]   w_raw, w_cut;

  // TRS preamble 3FF,000,000 sits in the last three words; the current word is XY.
  always_comb begin
    hist_d     = {hist_q[1:0], bt656_in};
    trs        = (hist_q[2] == 10'h3FF) && (hist_q[1] == 10'h000) && (hist_q[0] == 10'h000);
    eav        = trs && bt656_in[6];
    sav_act    = trs && !bt656_in[6] && !bt656_in[7];
    // A frame ends when F falls at an EAV.
    frame_tick = eav && field_q && !bt656_in[8];
    reseed_now = RESEED_EN && frame_tick && ((seed_cnt_q + 16'd1) >= RESEED_N);
    in_line    = (state_q inside {S_WAIT_EAV, S_REQ, S_HOLD, S_RUN});
    // 2**CUT_WIDTH < 2*ACTIVE_SAMPLES, so one conditional subtract is enough.
    w_raw      = word_q[CUT_WIDTH-1:0];
    w_cut      = (w_raw >= ACT_N) ? (w_raw - ACT_N) : w_raw;
  end

  // Only the low CUT_WIDTH bits of the random word take part in the cut.
  if (CUT_WIDTH < 16) begin : g_word_hi
    logic unused_word_hi;
    assign unused_word_hi = ^word_q[15:CUT_WIDTH];
  end

  always_comb begin
    field_d  = field_q;
    vblank_d = vblank_q;
    if (trs) begin
      field_d  = bt656_in[8];
      vblank_d = bt656_in[7];
    end

    frame_count_d = frame_count_q;
    if (frame_tick && (state_q != S_IDLE)) frame_count_d = frame_count_q + 16'd1;

    seed_cnt_d = seed_cnt_q;
    if (state_q == S_SEED)  seed_cnt_d = 16'd0;
    else if (frame_tick)    seed_cnt_d = seed_cnt_q + 16'd1;
  end

  always_comb begin
    state_d        = state_q;
    word_d         = word_q;
    cut_position_d = cut_position_q;
    cut_valid_d    = cut_valid_q;
    error_missed_d = error_missed_q;
    case (state_q)
      S_IDLE:      if (enable) state_d = S_SEED;
      S_SEED:      state_d = S_SEED_WAIT;
      S_SEED_WAIT: if (drbg_init_ready) state_d = S_WAIT_EAV;
      // The stream cannot tell us whether the next line is active, so request
      // at any EAV; the word simply waits in HOLD through blanking lines.
      S_WAIT_EAV:  if (eav) state_d = S_REQ;
      S_REQ: begin
        // Word not here at an active SAV: skip this line, keep requesting.
        if (sav_act) error_missed_d = 1'b1;
        if (drbg_bits_ready) begin
          word_d  = drbg_bits;
          state_d = S_HOLD;
        end
      end
      S_HOLD: if (sav_act) begin
        cut_position_d = w_cut;
        cut_valid_d    = 1'b1;
        state_d        = S_RUN;
      end
      S_RUN: if (eav) begin
        cut_valid_d = 1'b0;
        state_d     = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase

    // Line-end overrides: disable wins over reseed, reseed drops any request.
    if (eav && in_line) begin
      if (!enable) begin
        cut_valid_d = 1'b0;
        state_d     = S_IDLE;
      end else if (reseed_now) begin
        cut_valid_d = 1'b0;
        state_d     = S_SEED;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      hist_q         <= '0;
      field_q        <= 1'b0;
      vblank_q       <= 1'b0;
      word_q         <= '0;
      cut_position_q <= '0;
      cut_valid_q    <= 1'b0;
      frame_count_q  <= '0;
      seed_cnt_q     <= '0;
      error_missed_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      hist_q         <= hist_d;
      field_q        <= field_d;
      vblank_q       <= vblank_d;
      word_q         <= word_d;
      cut_position_q <= cut_position_d;
      cut_valid_q    <= cut_valid_d;
      frame_count_q  <= frame_count_d;
      seed_cnt_q     <= seed_cnt_d;
      error_missed_q <= error_missed_d;
    end
  end

  // Requests are gated by reset so a handshake drops in the reset cycle itself.
  assign drbg_init    = reset_n && (state_q == S_SEED);
  assign drbg_next    = reset_n && (state_q == S_REQ);
  assign cut_position = cut_position_q;
  assign cut_valid    = cut_valid_q;
  assign field        = field_q;
  assign vblank       = vblank_q;
  assign frame_count  = frame_count_q;
  assign error_missed = error_missed_q;

endmodule

// File: tb/tb_scramble_line_scheduler.sv
// Bench for scramble_line_scheduler: synthetic BT.656 frames, a DRBG
// responder, and a queue of expected cut positions checked at each cut.
module tb_scramble_line_scheduler;
  localparam int AS = 1440;

  logic        clk = 1'b0;
  logic        reset_n, enable, drbg_init, drbg_init_ready, drbg_next;
  logic        drbg_bits_ready, cut_valid, field, vblank, error_missed;
  logic [9:0]  bt656_in;
  logic [15:0] drbg_bits, frame_count;
  logic [10:0] cut_position;

  always #5 clk = ~clk;

  scramble_line_scheduler #(.ACTIVE_SAMPLES(AS), .CUT_WIDTH(11), .RESEED_FRAMES(2)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .bt656_in(bt656_in),
    .drbg_init(drbg_init), .drbg_init_ready(drbg_init_ready),
    .drbg_next(drbg_next), .drbg_bits_ready(drbg_bits_ready), .drbg_bits(drbg_bits),
    .cut_position(cut_position), .cut_valid(cut_valid), .field(field),
    .vblank(vblank), .frame_count(frame_count), .error_missed(error_missed)
  );

  typedef struct packed { logic [15:0] word; logic [10:0] cut; } vec_t;
  vec_t        tbl [5];
  vec_t        wq [$];
  logic [10:0] exp_q [$];

  int   n_vec = 0, n_err = 0;
  int   cuts = 0, init_pulses = 0, init_len = 0, cv_len = 0, init_cnt = 0;
  logic cv_prev = 1'b0, hold_ready = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // DRBG responder: init answered 3 cycles later, words 1 cycle after request.
  always begin : drbg_model
    vec_t v;
    @(posedge clk); #2;
    if (!reset_n) begin
      drbg_init_ready = 1'b0;
      drbg_bits_ready = 1'b0;
      init_cnt = 0;
    end else begin
      drbg_init_ready = 1'b0;
      if (init_cnt > 0) begin
        init_cnt--;
        if (init_cnt == 0) drbg_init_ready = 1'b1;
      end
      if (drbg_init) init_cnt = 3;
      if (drbg_next && !hold_ready && !drbg_bits_ready) begin
        if (wq.size() > 0) v = wq.pop_front();
        else begin
          v.word = 16'($urandom);
          v.cut  = v.word[10:0];
          if (v.cut >= 11'(AS)) v.cut = v.cut - 11'(AS);
        end
        drbg_bits       = v.word;
        drbg_bits_ready = 1'b1;
        exp_q.push_back(v.cut);
      end else drbg_bits_ready = 1'b0;
    end
  end

  // Cut / seed monitor on the falling edge.
  always @(negedge clk) begin
    if (drbg_init) init_len++;
    else if (init_len > 0) begin
      chk("init_pulse_len", init_len, 1);
      init_pulses++;
      init_len = 0;
    end
    if (cut_valid && !cv_prev) begin
      cuts++;
      cv_len = 0;
      chk("cut_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("cut_position", 32'(cut_position), 32'(exp_q.pop_front()));
    end
    if (cut_valid) cv_len++;
    else if (cv_prev) chk("cut_valid_len", cv_len, AS + 4);
    cv_prev = cut_valid;
  end

  task automatic put(input logic [9:0] w);
    @(posedge clk); #1;
    bt656_in = w;
  endtask

  task automatic send_trs(input logic f, input logic v, input logic h);
    put(10'h3FF); put(10'h000); put(10'h000);
    put({1'b1, f, v, h, 6'b0});
  endtask

  task automatic send_line(input logic f, input logic v, input int n,
                           input logic hset, input logic hrel);
    if (hset) hold_ready = 1'b1;
    send_trs(f, v, 1'b1);
    put(10'h200);
    chk("field", 32'(field), 32'(f));
    chk("vblank", 32'(vblank), 32'(v));
    repeat (7) put(10'h200);
    send_trs(f, v, 1'b0);
    for (int i = 0; i < n; i++) begin
      put(10'($urandom_range(4, 1019)));
      if (hrel && i == 10) hold_ready = 1'b0;
    end
  endtask

  task automatic wait_seed();
    int start = init_pulses;
    int k = 0;
    while (init_pulses == start && k < 30) begin
      put(10'h200);
      k++;
    end
    chk("seed_pulse_seen", init_pulses - start, 1);
    repeat (6) put(10'h200);
  endtask

  task automatic send_frame(input logic hset, input logic hrel);
    send_line(1'b0, 1'b1, 20, hset, 1'b0);
    send_line(1'b0, 1'b0, AS, 1'b0, hrel);
    send_line(1'b1, 1'b1, 20, 1'b0, 1'b0);
    send_line(1'b1, 1'b0, AS, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; bt656_in = 10'h200;
    drbg_init_ready = 1'b0; drbg_bits_ready = 1'b0; drbg_bits = '0;
    tbl[0] = '{16'h0123, 11'd291};
    tbl[1] = '{16'h07FF, 11'd607};
    tbl[2] = '{16'h05A0, 11'd0};
    tbl[3] = '{16'hF59F, 11'd1439};
    tbl[4] = '{16'h05A1, 11'd1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cut_valid", 32'(cut_valid), 0);
    chk("rst_cut_position", 32'(cut_position), 0);
    chk("rst_frame_count", 32'(frame_count), 0);
    chk("rst_error_missed", 32'(error_missed), 0);
    chk("rst_drbg_init", 32'(drbg_init), 0);
    chk("rst_drbg_next", 32'(drbg_next), 0);
    reset_n = 1'b1; enable = 1'b1;

    // Seed, then table words over three frames; frame 2's first active line is starved.
    for (int i = 0; i < 5; i++) wq.push_back(tbl[i]);
    wait_seed();
    chk("no_early_cut", cuts, 0);
    for (int f = 0; f < 3; f++) begin
      send_frame(f == 1, f == 1);
      if (f == 0) chk("error_missed_clear", 32'(error_missed), 0);
      if (f == 1) chk("error_missed_set", 32'(error_missed), 1);
    end
    hold_ready = 1'b1;
    send_trs(1'b0, 1'b1, 1'b1);
    repeat (4) put(10'h200);
    chk("a_frame_count", 32'(frame_count), 3);
    chk("a_cuts", cuts, 5);
    chk("a_init_pulses", init_pulses, 2);
    chk("a_words_left", exp_q.size(), 0);
    chk("cut_position_hold", 32'(cut_position), 1);
    chk("next_pending", 32'(drbg_next), 1);

    // Reset mid-handshake
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("next_drop_same_cycle", 32'(drbg_next), 0);
    @(posedge clk); #1;
    chk("rst2_drbg_next", 32'(drbg_next), 0);
    chk("rst2_cut_valid", 32'(cut_valid), 0);
    chk("rst2_frame_count", 32'(frame_count), 0);
    chk("rst2_error_missed", 32'(error_missed), 0);
    reset_n = 1'b1; hold_ready = 1'b0;
    exp_q.delete(); wq.delete();
    cuts = 0; init_pulses = 0;

    // Five frames with random words; reseed every two frames
    wait_seed();
    for (int f = 0; f < 5; f++) send_frame(1'b0, 1'b0);
    hold_ready = 1'b1;
    send_trs(1'b0, 1'b1, 1'b1);
    repeat (4) put(10'h200);
    chk("b_frame_count", 32'(frame_count), 5);
    chk("b_init_pulses", init_pulses, 3);
    chk("b_cuts", cuts, 10);
    chk("b_words_left", exp_q.size(), 0);
    chk("b_error_missed", 32'(error_missed), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
